// File: rtl/timer_display_scan.sv
// Six-digit multiplexed common-anode 7-segment driver for the countdown timer (HH.MM.SS).
// Snapshots the time once per frame, blinks the edited digit, and flashes the display at 00.00.00.
module timer_display_scan #(
  parameter int DIGIT_CYC = 2,
  parameter int BLINK_CYC = 250
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [5:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [2:0] digitp_i,
  input  logic       edit_i,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int SC_W = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam int BC_W = $clog2(BLINK_CYC);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(DIGIT_CYC - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_CYC - 1);

  logic [2:0]      idx_q, idx_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic            blink_on_q, blink_on_d;
  logic [5:0]      hour_q, min_q, sec_q;
  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       scan_last, frame_end, snap_zero, blink_en, blank;
  logic [3:0] digit;

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    digit      = 4'd0;
    scan_last  = (sc_q == SC_LAST);
    frame_end  = scan_last && (idx_q == 3'd5);
    snap_zero  = ((hour_q | min_q | sec_q) == 6'd0);
    blink_en   = edit_i | snap_zero;

    case (idx_q)
      3'd0:    digit = tens(hour_q);
      3'd1:    digit = ones(hour_q);
      3'd2:    digit = tens(min_q);
      3'd3:    digit = ones(min_q);
      3'd4:    digit = tens(sec_q);
      3'd5:    digit = ones(sec_q);
      default: digit = 4'd0;
    endcase

    // Positions 6/7 never equal idx, so an out-of-range edit pointer never blanks.
    blank = !blink_on_q && (edit_i ? (idx_q == digitp_i) : snap_zero);
    an_d  = blank ? 6'b111111 : ~(6'b000001 << idx_q);
    seg_d = seg_code(digit);
    dp_d  = !((idx_q == 3'd1) || (idx_q == 3'd3));

    sc_d  = scan_last ? '0 : sc_q + 1'b1;
    idx_d = idx_q;
    if (scan_last) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    bc_d       = '0;
    blink_on_d = 1'b1;
    if (blink_en) begin
      bc_d       = (bc_q == BC_LAST) ? '0 : bc_q + 1'b1;
      blink_on_d = (bc_q == BC_LAST) ? ~blink_on_q : blink_on_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q      <= 3'd0;
      sc_q       <= '0;
      bc_q       <= '0;
      blink_on_q <= 1'b1;
      hour_q     <= 6'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      an_q       <= 6'b111111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      idx_q      <= idx_d;
      sc_q       <= sc_d;
      bc_q       <= bc_d;
      blink_on_q <= blink_on_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      if (frame_end) begin
        hour_q <= hour_i;
        min_q  <= min_i;
        sec_q  <= sec_i;
      end
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_timer_display_scan.sv
// Randomized scoreboard bench for timer_display_scan against a cycle-count based reference model.
module tb_timer_display_scan;

  localparam int DC    = 2;
  localparam int BC    = 4;
  localparam int FRAME = 6 * DC;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] hour, mins, secs;
  logic [2:0] digitp;
  logic       edit;
  logic [5:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  int checks = 0;
  int errors = 0;

  exp_t q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model state: cycle number since reset release, consecutive blink-enable cycles,
  // the time shown in the current frame and the time captured for the next one.
  int         t;
  int         run;
  logic [5:0] snap_h, snap_m, snap_s;
  logic [5:0] cap_h, cap_m, cap_s;

  always #5 clk = ~clk;

  timer_display_scan #(.DIGIT_CYC(DC), .BLINK_CYC(BC)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .hour_i   (hour),
    .min_i    (mins),
    .sec_i    (secs),
    .digitp_i (digitp),
    .edit_i   (edit),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    run    = 0;
    snap_h = 0; snap_m = 0; snap_s = 0;
    cap_h  = 0; cap_m  = 0; cap_s  = 0;
  endtask

  // One clock cycle: derive the expected registered output from the current inputs,
  // then let the edge happen and hand the expectation to the monitor.
  task automatic step();
    exp_t e;
    int   pos;
    int   dig [6];
    bit   zero, en, lit, blank;
    if (t > 0 && t % FRAME == 0) begin
      snap_h = cap_h; snap_m = cap_m; snap_s = cap_s;
    end
    pos    = (t / DC) % 6;
    zero   = (snap_h == 0) && (snap_m == 0) && (snap_s == 0);
    en     = edit || zero;
    lit    = ((run / BC) % 2) == 0;
    blank  = !lit && (edit ? (int'(digitp) == pos) : zero);
    dig[0] = snap_h / 10; dig[1] = snap_h % 10;
    dig[2] = snap_m / 10; dig[3] = snap_m % 10;
    dig[4] = snap_s / 10; dig[5] = snap_s % 10;
    e.an   = blank ? 6'b111111 : ~(6'b000001 << pos);
    e.seg  = seg_tab[dig[pos]];
    e.dp   = !(pos == 1 || pos == 3);
    run    = en ? run + 1 : 0;
    if (t % FRAME == FRAME - 1) begin
      cap_h = hour; cap_m = mins; cap_s = secs;
    end
    @(posedge clk);
    q.push_back(e);
    #1;
    t++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("an", an_o, e.an);
        check("seg", seg_o, e.seg);
        check("dp", dp_o, e.dp);
        check("one_anode", $countones(~an_o) <= 1, 1);
      end
    end
  end

  initial begin : stimulus
    reset_n = 1'b0;
    hour = 6'd12; mins = 6'd0; secs = 6'd0;
    edit = 1'b0; digitp = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an_o, 6'b111111);
    check("rst_seg", seg_o, 7'b1111111);
    check("rst_dp", dp_o, 1'b1);
    reset_n = 1'b1;

    // First frame shows a flashing 00.00.00 even though hour_i is 12.
    run_cycles(FRAME);
    hour = 6'd1; mins = 6'd5; secs = 6'd9;
    run_cycles(3 * FRAME);

    // Tearing: change seconds while the minutes tens digit is on.
    while ((t / DC) % 6 != 2) step();
    secs = 6'd10;
    run_cycles(2 * FRAME);

    // Edit blink on minute ones, then an out-of-range pointer.
    edit = 1'b1; digitp = 3'd3;
    run_cycles(4 * FRAME);
    digitp = 3'd7;
    run_cycles(2 * FRAME);

    // Zero flash, then a non-zero time stops it.
    edit = 1'b0; hour = 0; mins = 0; secs = 0;
    run_cycles(4 * FRAME);
    secs = 6'd1;
    run_cycles(3 * FRAME);

    // Randomized inputs, with occasional all-zero time and edit bursts.
    repeat (60) begin
      hour   = 6'($urandom_range(0, 63));
      mins   = 6'($urandom_range(0, 59));
      secs   = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 3) == 0) begin
        hour = 0; mins = 0; secs = 0;
      end
      edit   = ($urandom_range(0, 2) == 0);
      digitp = 3'($urandom_range(0, 7));
      run_cycles($urandom_range(1, 2 * FRAME));
    end

    // Reset in the middle of a scan while position 4 is current.
    hour = 6'd23; mins = 6'd45; secs = 6'd54; edit = 1'b0;
    run_cycles(2 * FRAME);
    while ((t / DC) % 6 != 4) step();
    reset_n = 1'b0;
    q.delete();
    #1;
    check("midrst_an", an_o, 6'b111111);
    check("midrst_seg", seg_o, 7'b1111111);
    check("midrst_dp", dp_o, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    run_cycles(3 * FRAME);

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
